t_latch: RTL and testbench
==========================

# t_latch

Clocked toggle (T) storage element: on each rising clock edge, every bit of `q` whose `t` input is high inverts, and every bit whose `t` is low holds. It is a leaf primitive of the flip-flop library, used as a divide-by-two stage or toggle register. It also provides an inverted output, a one-cycle "toggled" flag and a wrapping toggle counter for debug and observability.

## Interface
- `WIDTH`, default 1: number of independent toggle bits.
- `RESET_VAL`, default all-zero (`WIDTH` bits): value loaded into `q` on reset.
- `CNT_W`, default 8: width of `toggle_cnt`.
- `clk`, input, 1 bit: single clock; all state updates on its rising edge.
- `reset`, input, 1 bit: synchronous, active-low reset. Sampled only on the rising edge of `clk`; `reset = 0` at an edge resets the block.
- `t`, input, `WIDTH` bits: per-bit toggle request, sampled at the rising edge of `clk`.
- `q`, output, `WIDTH` bits: registered state.
- `qn`, output, `WIDTH` bits: always `~q` (combinational).
- `toggled`, output, 1 bit: registered; high for exactly one cycle after any bit of `q` changed.
- `toggle_cnt`, output, `CNT_W` bits: registered count of edges at which at least one bit toggled.

## Operation
- Reset edge (`reset = 0` at posedge `clk`):
  - `q <= RESET_VAL`
  - `toggled <= 0`
  - `toggle_cnt <= 0`
  - `t` is ignored.
- Normal edge (`reset = 1`):
  - `q <= q ^ t`
  - `toggled <= |t`
  - `toggle_cnt <= toggle_cnt + 1` if `|t`, otherwise hold.
- `toggle_cnt` wraps modulo 2^`CNT_W`: all-ones + 1 gives 0, with no saturation and no flag.
- Bits of `q` are fully independent; there is no interaction between bits.
- `t` held high continuously: `q` toggles on every edge, so each bit runs at `clk`/2.
- Reset asserted mid-sequence: reset takes priority over `t` at that edge. Toggling resumes on the first edge at which `reset = 1`.
- No latch and no asynchronous path: despite the name, the block is edge-triggered.

## Timing
- Latency: `t` sampled at edge N is reflected on `q`, `toggled` and `toggle_cnt` immediately after edge N. This is one register stage, with no additional pipeline.
- `qn` follows `q` combinationally within the same cycle.
- Before the first reset edge, outputs are undefined (X in simulation). The bench must apply reset for at least one edge.
- Setup/hold: `t` and `reset` must be stable around the rising edge of `clk`. Changes between edges have no effect.

## Structure
- No shared package needed; all parameters are local to the block.
- Natural sub-module: `t_ff_bit`, a 1-bit toggle cell with synchronous active-low reset and a reset-value input. `t_latch` instantiates `WIDTH` copies of it via generate.
- `t_latch` itself contains only the OR-reduction of `t`, the `toggled` register, the `toggle_cnt` counter and the `qn` inversion.

## Test plan
Defaults unless stated: `WIDTH = 1`, `CNT_W = 8`, `RESET_VAL = 0`, 10-time-unit clock period.

1. Reset: hold `reset = 0`, `t = 0` for 2 edges → `q = 0`, `qn = 1`, `toggled = 0`, `toggle_cnt = 0`. Also with `t = 1` during reset → same values.
2. Toggle/hold sequence: after reset is released, apply `t` = 1, 1, 0, 1, 0 on successive edges → `q` = 1, 0, 0, 1, 1; `toggled` = 1, 1, 0, 1, 0; final `toggle_cnt = 3`.
3. Continuous toggle: `t = 1` for 8 edges → `q` alternates 1, 0, 1, … with period 2 cycles; `qn` is always the complement; `toggle_cnt = 8`.
4. Reset mid-operation: with `q = 1` and `t = 1`, drive `reset = 0` for one edge → `q = 0`, `toggle_cnt = 0`; the next edge with `reset = 1`, `t = 1` → `q = 1`.
5. Counter wrap: set `CNT_W = 2` and apply 5 toggling edges → `toggle_cnt` = 1, 2, 3, 0, 1.
6. Multi-bit: `WIDTH = 4`, `RESET_VAL = 4'b1010`, reset, then `t = 4'b0110` for one edge → `q = 4'b1100`, `qn = 4'b0011`, `toggled = 1`.

Source files
------------

// File: rtl/t_latch_pkg.sv
// ----------------------------------------------------------------------------
// t_latch_pkg
// Shared constants for the toggle register slice. Holds the default
// parameter values for t_latch so that any wrapper or instantiating block
// can refer to the same defaults by name.
// ----------------------------------------------------------------------------
package t_latch_pkg;

    // Default number of independent toggle bits.
    localparam int unsigned DefaultWidth = 1;

    // Default width of the wrapping toggle-event counter.
    localparam int unsigned DefaultCntW = 8;

endpackage : t_latch_pkg

// File: rtl/t_latch_t_ff_bit.sv
// ----------------------------------------------------------------------------
// t_ff_bit
// One-bit toggle cell. On each rising clock edge the stored bit inverts when
// t_i is high and holds when it is low. A low reset at the edge loads
// rst_val_i instead, and t_i is ignored at that edge.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous, active-low reset
//   t_i        - toggle request for this bit
//   rst_val_i  - value loaded on reset
//   q_o        - registered bit
// ----------------------------------------------------------------------------
module t_ff_bit (
    input  logic clk,
    input  logic reset,
    input  logic t_i,
    input  logic rst_val_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Next state is the current bit XOR the toggle request, so a high t_i
    // flips the bit and a low t_i holds it.
    always_comb begin
        q_d = q_q ^ t_i;
    end

    // State register. Reset wins over the toggle request at the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q <= rst_val_i;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : t_ff_bit

// File: rtl/t_latch.sv
// ----------------------------------------------------------------------------
// t_latch
// Clocked toggle register, edge-triggered despite the name. Each bit of q
// inverts on a rising edge where its t bit is high and holds otherwise.
// Also provides the inverted state, a one-cycle flag that is high after any
// edge where some bit toggled, and a wrapping count of such edges.
//
// Parameters:
//   WIDTH      - number of independent toggle bits
//   RESET_VAL  - value loaded into q on reset
//   CNT_W      - width of toggle_cnt
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous, active-low reset
//   t          - per-bit toggle request
//   q          - registered state
//   qn         - combinational complement of q
//   toggled    - registered, high for one cycle after any bit changed
//   toggle_cnt - registered count of edges with at least one toggle (wraps)
// ----------------------------------------------------------------------------
module t_latch
    import t_latch_pkg::*;
#(
    parameter int unsigned          WIDTH     = DefaultWidth,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0,
    parameter int unsigned          CNT_W     = DefaultCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             toggled,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic             anyToggle;
    logic             toggled_q;
    logic             toggled_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // One toggle cell per bit; the bits share nothing but clock and reset.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        t_ff_bit u_bit (
            .clk       (clk),
            .reset     (reset),
            .t_i       (t[i]),
            .rst_val_i (RESET_VAL[i]),
            .q_o       (q[i])
        );
    end

    // Any high request bit means the register content changes at this edge.
    assign anyToggle = |t;

    // The flag simply mirrors whether a toggle happened at the last edge, and
    // the counter advances by one per toggling edge. The counter is left to
    // wrap naturally at its width; there is no saturation.
    always_comb begin
        toggled_d = anyToggle;
        cnt_d     = cnt_q;
        if (anyToggle) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Flag and counter registers, cleared by the same synchronous reset that
    // reloads the toggle cells.
    always_ff @(posedge clk) begin
        if (!reset) begin
            toggled_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            toggled_q <= toggled_d;
            cnt_q     <= cnt_d;
        end
    end

    assign qn         = ~q;
    assign toggled    = toggled_q;
    assign toggle_cnt = cnt_q;

endmodule : t_latch

// File: tb/tb_t_latch.sv
// ----------------------------------------------------------------------------
// tb_t_latch
// Directed bench for t_latch. Three instances cover the default
// configuration, a 2-bit counter for wrap behaviour, and a 4-bit register
// with a non-zero reset value. Inputs change 1 time unit after each rising
// edge and outputs are sampled at the same point, away from the edge.
// ----------------------------------------------------------------------------
module tb_t_latch;

    logic       clk;
    int         errors;
    int         checks;

    // Instance A: defaults (WIDTH=1, CNT_W=8, RESET_VAL=0)
    logic       resetA;
    logic [0:0] tA;
    logic [0:0] qA;
    logic [0:0] qnA;
    logic       toggledA;
    logic [7:0] cntA;

    // Instance B: CNT_W=2 for the wrap test
    logic       resetB;
    logic [0:0] tB;
    logic [0:0] qB;
    logic [0:0] qnB;
    logic       toggledB;
    logic [1:0] cntB;

    // Instance C: WIDTH=4, RESET_VAL=4'b1010
    logic       resetC;
    logic [3:0] tC;
    logic [3:0] qC;
    logic [3:0] qnC;
    logic       toggledC;
    logic [7:0] cntC;

    t_latch u_dutA (
        .clk        (clk),
        .reset      (resetA),
        .t          (tA),
        .q          (qA),
        .qn         (qnA),
        .toggled    (toggledA),
        .toggle_cnt (cntA)
    );

    t_latch #(.WIDTH(1), .RESET_VAL(1'b0), .CNT_W(2)) u_dutB (
        .clk        (clk),
        .reset      (resetB),
        .t          (tB),
        .q          (qB),
        .qn         (qnB),
        .toggled    (toggledB),
        .toggle_cnt (cntB)
    );

    t_latch #(.WIDTH(4), .RESET_VAL(4'b1010), .CNT_W(8)) u_dutC (
        .clk        (clk),
        .reset      (resetC),
        .t          (tC),
        .q          (qC),
        .qn         (qnC),
        .toggled    (toggledC),
        .toggle_cnt (cntC)
    );

    // 10-time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    // Reset with t low, then with t high; both must give the reset state.
    task automatic test_reset();
        logic [0:0] tVals [2];
        tVals[0] = 1'b0;
        tVals[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            resetA = 1'b0;
            tA     = tVals[k];
            nextEdge();
            nextEdge();
            checks++;
            if (qA !== 1'b0 || qnA !== 1'b1 || toggledA !== 1'b0 || cntA !== 8'd0) begin
                errors++;
                $display("[TB] FAIL reset(t=%0b): q=%b qn=%b toggled=%b cnt=%0d, expected q=0 qn=1 toggled=0 cnt=0",
                         tVals[k], qA, qnA, toggledA, cntA);
            end
        end
    endtask

    // Toggle/hold sequence t = 1,1,0,1,0 from q = 0.
    task automatic test_toggle_hold();
        logic [0:0] tSeq   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [0:0] qExp   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       togExp [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        resetA = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tA = tSeq[i];
            nextEdge();
            checks++;
            if (qA !== qExp[i] || toggledA !== togExp[i] || qnA !== ~qExp[i]) begin
                errors++;
                $display("[TB] FAIL toggle_hold step %0d: q=%b qn=%b toggled=%b, expected q=%b qn=%b toggled=%b",
                         i, qA, qnA, toggledA, qExp[i], ~qExp[i], togExp[i]);
            end
        end
        checks++;
        if (cntA !== 8'd3) begin
            errors++;
            $display("[TB] FAIL toggle_hold count: cnt=%0d, expected 3", cntA);
        end
    endtask

    // Reset, then t held high for 8 edges: q alternates starting at 1.
    task automatic test_continuous();
        logic [0:0] qExp;
        resetA = 1'b0;
        tA     = 1'b0;
        nextEdge();
        resetA = 1'b1;
        tA     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            nextEdge();
            qExp = (i % 2 == 0) ? 1'b1 : 1'b0;
            checks++;
            if (qA !== qExp || qnA !== ~qExp || toggledA !== 1'b1) begin
                errors++;
                $display("[TB] FAIL continuous edge %0d: q=%b qn=%b toggled=%b, expected q=%b qn=%b toggled=1",
                         i, qA, qnA, toggledA, qExp, ~qExp);
            end
        end
        checks++;
        if (cntA !== 8'd8) begin
            errors++;
            $display("[TB] FAIL continuous count: cnt=%0d, expected 8", cntA);
        end
    endtask

    // Continuing from q = 0, cnt = 8: one toggle to reach q = 1, then a reset
    // edge with t high, then resume toggling.
    task automatic test_reset_mid();
        resetA = 1'b1;
        tA     = 1'b1;
        nextEdge();
        checks++;
        if (qA !== 1'b1 || cntA !== 8'd9) begin
            errors++;
            $display("[TB] FAIL reset_mid setup: q=%b cnt=%0d, expected q=1 cnt=9", qA, cntA);
        end
        resetA = 1'b0;
        nextEdge();
        checks++;
        if (qA !== 1'b0 || cntA !== 8'd0 || toggledA !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid reset: q=%b cnt=%0d toggled=%b, expected q=0 cnt=0 toggled=0",
                     qA, cntA, toggledA);
        end
        resetA = 1'b1;
        nextEdge();
        checks++;
        if (qA !== 1'b1 || cntA !== 8'd1 || toggledA !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid resume: q=%b cnt=%0d toggled=%b, expected q=1 cnt=1 toggled=1",
                     qA, cntA, toggledA);
        end
    endtask

    // 2-bit counter over 5 toggling edges: 1, 2, 3, 0, 1.
    task automatic test_counter_wrap();
        logic [1:0] cntExp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        resetB = 1'b0;
        tB     = 1'b1;
        nextEdge();
        checks++;
        if (cntB !== 2'd0 || qB !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wrap reset: cnt=%0d q=%b, expected cnt=0 q=0", cntB, qB);
        end
        resetB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextEdge();
            checks++;
            if (cntB !== cntExp[i]) begin
                errors++;
                $display("[TB] FAIL wrap edge %0d: cnt=%0d, expected %0d", i, cntB, cntExp[i]);
            end
        end
    endtask

    // 4-bit register with reset value 1010, one edge of t = 0110, then hold.
    task automatic test_multibit();
        resetC = 1'b0;
        tC     = 4'b1111;
        nextEdge();
        checks++;
        if (qC !== 4'b1010 || qnC !== 4'b0101 || toggledC !== 1'b0 || cntC !== 8'd0) begin
            errors++;
            $display("[TB] FAIL multibit reset: q=%b qn=%b toggled=%b cnt=%0d, expected q=1010 qn=0101 toggled=0 cnt=0",
                     qC, qnC, toggledC, cntC);
        end
        resetC = 1'b1;
        tC     = 4'b0110;
        nextEdge();
        checks++;
        if (qC !== 4'b1100 || qnC !== 4'b0011 || toggledC !== 1'b1 || cntC !== 8'd1) begin
            errors++;
            $display("[TB] FAIL multibit toggle: q=%b qn=%b toggled=%b cnt=%0d, expected q=1100 qn=0011 toggled=1 cnt=1",
                     qC, qnC, toggledC, cntC);
        end
        tC = 4'b0000;
        nextEdge();
        checks++;
        if (qC !== 4'b1100 || toggledC !== 1'b0 || cntC !== 8'd1) begin
            errors++;
            $display("[TB] FAIL multibit hold: q=%b toggled=%b cnt=%0d, expected q=1100 toggled=0 cnt=1",
                     qC, toggledC, cntC);
        end
        tC = 4'b1001;
        nextEdge();
        checks++;
        if (qC !== 4'b0101 || qnC !== 4'b1010 || toggledC !== 1'b1 || cntC !== 8'd2) begin
            errors++;
            $display("[TB] FAIL multibit outer: q=%b qn=%b toggled=%b cnt=%0d, expected q=0101 qn=1010 toggled=1 cnt=2",
                     qC, qnC, toggledC, cntC);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        errors = 0;
        checks = 0;
        resetA = 1'b0;
        resetB = 1'b0;
        resetC = 1'b0;
        tA     = 1'b0;
        tB     = 1'b0;
        tC     = 4'b0000;
        #1;

        test_reset();
        test_toggle_hold();
        test_continuous();
        test_reset_mid();
        test_counter_wrap();
        test_multibit();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_t_latch
